// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS 8b/10b encoder: transition minimisation then DC balance, 2-cycle latency.
// Defining DVI_TMDS_IN_REG_EN adds an input register stage (latency 3).
module dvi_tmds_encoder (
  input  logic       i_pix_clk,
  input  logic       i_rst,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  input  logic       i_de,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_tmds_red,
  output logic [9:0] o_tmds_green,
  output logic [9:0] o_tmds_blue,
  output logic       o_de
);

  localparam logic [9:0] CtrlSym00 = 10'b1101010100;
  localparam logic [9:0] CtrlSym01 = 10'b0010101011;
  localparam logic [9:0] CtrlSym10 = 10'b0101010100;
  localparam logic [9:0] CtrlSym11 = 10'b1010101011;

  typedef logic signed [5:0] disp_t;

  function automatic logic [8:0] tm_min(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'd0, d[i]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q    = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next disparity, symbol}.
  function automatic logic [15:0] dc_balance(input logic [8:0] qm, input disp_t cnt);
    logic [3:0] n1q;
    disp_t      diff;
    disp_t      two_q8;
    disp_t      two_nq8;
    disp_t      cnt_n;
    logic [9:0] sym;
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'd0, qm[i]};
    diff    = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    two_q8  = qm[8] ? 6'sd2 : 6'sd0;
    two_nq8 = qm[8] ? 6'sd0 : 6'sd2;
    if ((cnt == 6'sd0) || (diff == 6'sd0)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 6'sd0) && (diff > 6'sd0)) || ((cnt < 6'sd0) && (diff < 6'sd0))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + two_q8 - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - two_nq8 + diff;
    end
    return {cnt_n, sym};
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00:   s = CtrlSym00;
      2'b01:   s = CtrlSym01;
      2'b10:   s = CtrlSym10;
      default: s = CtrlSym11;
    endcase
    return s;
  endfunction

  // Channel index: 2 = red, 1 = green, 0 = blue.
  logic [7:0] s1_pix [3];
  logic       s1_de, s1_hs, s1_vs;

`ifdef DVI_TMDS_IN_REG_EN
  logic [7:0] in_pix_q [3];
  logic       in_de_q, in_hs_q, in_vs_q;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      for (int ch = 0; ch < 3; ch++) in_pix_q[ch] <= 8'd0;
      in_de_q <= 1'b0;
      in_hs_q <= 1'b0;
      in_vs_q <= 1'b0;
    end else begin
      in_pix_q[2] <= i_red;
      in_pix_q[1] <= i_green;
      in_pix_q[0] <= i_blue;
      in_de_q     <= i_de;
      in_hs_q     <= i_hs;
      in_vs_q     <= i_vs;
    end
  end

  assign s1_pix[2] = in_pix_q[2];
  assign s1_pix[1] = in_pix_q[1];
  assign s1_pix[0] = in_pix_q[0];
  assign s1_de     = in_de_q;
  assign s1_hs     = in_hs_q;
  assign s1_vs     = in_vs_q;
`else
  assign s1_pix[2] = i_red;
  assign s1_pix[1] = i_green;
  assign s1_pix[0] = i_blue;
  assign s1_de     = i_de;
  assign s1_hs     = i_hs;
  assign s1_vs     = i_vs;
`endif

  logic [8:0] qm_q [3];
  logic       de_q, hs_q, vs_q;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      for (int ch = 0; ch < 3; ch++) qm_q[ch] <= 9'd0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) qm_q[ch] <= tm_min(s1_pix[ch]);
      de_q <= s1_de;
      hs_q <= s1_hs;
      vs_q <= s1_vs;
    end
  end

  disp_t      cnt_q [3];
  disp_t      cnt_d [3];
  logic [9:0] sym_q [3];
  logic [9:0] sym_d [3];
  logic       de_out_q;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      {cnt_d[ch], sym_d[ch]} = dc_balance(qm_q[ch], cnt_q[ch]);
      if (!de_q) begin
        // Only the blue channel carries sync; the others send the 00 control token.
        sym_d[ch] = ctrl_sym((ch == 0) ? {vs_q, hs_q} : 2'b00);
        cnt_d[ch] = 6'sd0;
      end
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= 6'sd0;
        sym_q[ch] <= CtrlSym00;
      end
      de_out_q <= 1'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
        sym_q[ch] <= sym_d[ch];
      end
      de_out_q <= de_q;
    end
  end

  assign o_tmds_red   = sym_q[2];
  assign o_tmds_green = sym_q[1];
  assign o_tmds_blue  = sym_q[0];
  assign o_de         = de_out_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Directed-vector bench for dvi_tmds_encoder, plus mid-line reset and a modelled random stream.
module tb_dvi_tmds_encoder;

`ifdef DVI_TMDS_IN_REG_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam int NVec = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] red, green, blue;
  logic       de, hs, vs;
  logic [9:0] t_red, t_green, t_blue;
  logic       de_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dvi_tmds_encoder dut (
    .i_pix_clk   (clk),
    .i_rst       (rst),
    .i_red       (red),
    .i_green     (green),
    .i_blue      (blue),
    .i_de        (de),
    .i_hs        (hs),
    .i_vs        (vs),
    .o_tmds_red  (t_red),
    .o_tmds_green(t_green),
    .o_tmds_blue (t_blue),
    .o_de        (de_o)
  );

  typedef struct {
    logic       de, hs, vs;
    logic [7:0] r, g, b;
    logic [9:0] er, eg, eb;
  } vec_t;

  typedef struct {
    logic [9:0] er, eg, eb;
    logic       ede;
  } exp_t;

  vec_t tbl [NVec];
  exp_t expq [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic h, input logic v,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    de = d; hs = h; vs = v; red = r; green = g; blue = b;
  endtask

  task automatic chk(input string name, input logic [9:0] er, input logic [9:0] eg,
                     input logic [9:0] eb, input logic ede);
    n_vec++;
    if (t_red !== er || t_green !== eg || t_blue !== eb || de_o !== ede) begin
      n_fail++;
      $display("FAIL %s: got r=%b g=%b b=%b de=%b, want r=%b g=%b b=%b de=%b",
               name, t_red, t_green, t_blue, de_o, er, eg, eb, ede);
    end
  endtask

  // Reference encoder written from the algorithm description, using integer disparity.
  function automatic logic [9:0] ref_sym(input logic [7:0] d, input logic den, input logic c1,
                                         input logic c0, input int cnt_in, output int cnt_out);
    int         n1, n1q, n0q;
    logic       xn;
    logic [8:0] qm;
    logic [9:0] s;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm = 9'd0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (!den) begin
      cnt_out = 0;
      case ({c1, c0})
        2'b00:   s = C00;
        2'b01:   s = C01;
        2'b10:   s = C10;
        default: s = C11;
      endcase
    end else if (cnt_in == 0 || n1q == n0q) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? 2 : 0) + (n0q - n1q);
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - (qm[8] ? 0 : 2) + (n1q - n0q);
    end
    return s;
  endfunction

  initial begin
    int   cnt_r, cnt_g, cnt_b;
    exp_t e;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C01};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, C00, C00, C10};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, C00, C00, C11};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,
                10'b0100000000, 10'b0100000000, 10'b0100000000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00,
                10'b1111111111, 10'b1111111111, 10'b1111111111};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C00};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF,
                10'b1000000000, 10'b1000000000, 10'b1000000000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF,
                10'b0011111111, 10'b0011111111, 10'b0011111111};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF,
                10'b0011111111, 10'b0011111111, 10'b0011111111};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF,
                10'b1000000000, 10'b1000000000, 10'b1000000000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h0F, 8'h10,
                10'b0111111111, 10'b1111111010, 10'b0111110000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h0F, 8'h10,
                10'b1100000000, 10'b0100000101, 10'b0111110000};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00,
                10'b1111111111, 10'b1111111111, 10'b1111111111};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, C00, C00, C01};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h80,
                10'b0100000000, 10'b1000000000, 10'b0110000000};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h1E,
                10'b1111111111, 10'b0011111111, 10'b1001011111};

    // Reset held with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
      step();
      chk($sformatf("rst_hold%0d", i), C00, C00, C00, 1'b0);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_release%0d", i), C00, C00, C00, 1'b0);
    end

    // Directed table, output of vector k appears Lat edges after it is applied.
    for (int j = 0; j < NVec + Lat - 1; j++) begin
      if (j < NVec) drive(tbl[j].de, tbl[j].hs, tbl[j].vs, tbl[j].r, tbl[j].g, tbl[j].b);
      else          drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step();
      if (j >= Lat - 1) begin
        chk($sformatf("vec%0d", j - (Lat - 1)), tbl[j-(Lat-1)].er, tbl[j-(Lat-1)].eg,
            tbl[j-(Lat-1)].eb, tbl[j-(Lat-1)].de);
      end
    end

    // Mid-line reset: disparity is nonzero before the pulse, zero after.
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_edge", C00, C00, C00, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int k = 1; k < Lat; k++) begin
      step();
      chk($sformatf("midrst_flush%0d", k), C00, C00, C00, 1'b0);
    end
    step();
    chk("midrst_first", 10'b0100000000, 10'b0100000000, 10'b0100000000, 1'b1);
    step();
    chk("midrst_second", 10'b1111111111, 10'b1111111111, 10'b1111111111, 1'b1);

    // Idle so every channel's disparity is back to zero, then a modelled random stream.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < Lat + 1; i++) step();
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 3000; i++) begin
      drive((i % 80) < 64, 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
      e.er  = ref_sym(red,   de, 1'b0, 1'b0, cnt_r, cnt_r);
      e.eg  = ref_sym(green, de, 1'b0, 1'b0, cnt_g, cnt_g);
      e.eb  = ref_sym(blue,  de, vs,   hs,   cnt_b, cnt_b);
      e.ede = de;
      expq.push_back(e);
      step();
      if (expq.size() == Lat) begin
        e = expq.pop_front();
        chk($sformatf("rand%0d", i), e.er, e.eg, e.eb, e.ede);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
